rgb_axis_packer: RTL



---
 rtl/ray_video_pkg.sv | 23 ++
 rtl/rgb_axis_packer_if.sv | 26 ++
 rtl/axis_out_reg.sv | 49 ++++
 rtl/rgb_axis_packer.sv | 137 +++++++++++++
 4 files changed

// File: rtl/ray_video_pkg.sv
// Shared video packing types: packer state, byte geometry and tkeep mask helper.
// No logic of its own; no latency or backpressure.
package ray_video_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } pack_state_t;

    localparam int BYTES_PER_PIXEL = 3;
    localparam int BYTES_PER_WORD  = 4;

    // Low n lanes valid; n of 4 or more gives a full mask.
    function automatic logic [3:0] keep_from_count(input logic [2:0] n);
        logic [3:0] k;
        k = '0;
        for (int i = 0; i < BYTES_PER_WORD; i++) begin
            if (3'(i) < n) k[i] = 1'b1;
        end
        return k;
    endfunction

endpackage

// File: rtl/rgb_axis_packer_if.sv
// Pixel input bundle and 32-bit AXI4-Stream output bundle.
// Pure wiring; backpressure carried by in_stream_ready / out_tready.
interface rgb_pix_if;
    logic       in_valid;
    logic [7:0] in_r;
    logic [7:0] in_g;
    logic [7:0] in_b;
    logic       in_sof;
    logic       in_eol;
    logic       in_stream_ready;

    modport master (output in_valid, in_r, in_g, in_b, in_sof, in_eol, input in_stream_ready);
    modport slave  (input in_valid, in_r, in_g, in_b, in_sof, in_eol, output in_stream_ready);
endinterface

interface rgb_axis_if #(parameter int DATA_W = 32);
    logic [DATA_W-1:0]   out_tdata;
    logic [DATA_W/8-1:0] out_tkeep;
    logic                out_tuser;
    logic                out_tlast;
    logic                out_tvalid;
    logic                out_tready;

    modport master (output out_tdata, out_tkeep, out_tuser, out_tlast, out_tvalid, input out_tready);
    modport slave  (input out_tdata, out_tkeep, out_tuser, out_tlast, out_tvalid, output out_tready);
endinterface

// File: rtl/axis_out_reg.sv
// AXI-Stream output register: one word is visible 1 cycle after load.
// Word held while tvalid && !tready; ld_rdy allows consume and reload in one cycle.
module axis_out_reg #(
    parameter int DATA_W = 32
) (
    input  logic                aclk,
    input  logic                aresetn,
    input  logic                ld_vld,
    output logic                ld_rdy,
    input  logic [DATA_W-1:0]   ld_tdata,
    input  logic [DATA_W/8-1:0] ld_tkeep,
    input  logic                ld_tuser,
    input  logic                ld_tlast,
    rgb_axis_if.master          axis
);

    logic [DATA_W-1:0]   tdata_q;
    logic [DATA_W/8-1:0] tkeep_q;
    logic                tuser_q;
    logic                tlast_q;
    logic                tvalid_q;

    assign ld_rdy = !tvalid_q || axis.out_tready;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            tdata_q  <= '0;
            tkeep_q  <= '0;
            tuser_q  <= 1'b0;
            tlast_q  <= 1'b0;
            tvalid_q <= 1'b0;
        end else if (ld_vld && ld_rdy) begin
            tdata_q  <= ld_tdata;
            tkeep_q  <= ld_tkeep;
            tuser_q  <= ld_tuser;
            tlast_q  <= ld_tlast;
            tvalid_q <= 1'b1;
        end else if (axis.out_tready) begin
            tvalid_q <= 1'b0;
        end
    end

    assign axis.out_tdata  = tdata_q;
    assign axis.out_tkeep  = tkeep_q;
    assign axis.out_tuser  = tuser_q;
    assign axis.out_tlast  = tlast_q;
    assign axis.out_tvalid = tvalid_q;

endmodule

// File: rtl/rgb_axis_packer.sv
// Packs 24-bit RGB pixels byte-contiguously into 32-bit AXI-Stream words (4 px -> 3 words); 1-cycle latency.
// Stalls input while the output word is held, and for one cycle after an EOL that spills past one word.
module rgb_axis_packer
    import ray_video_pkg::*;
#(
    parameter int         DATA_W    = 32,
    parameter logic [7:0] FLUSH_PAD = 8'h00
) (
    input  logic       aclk,
    input  logic       aresetn,
    rgb_pix_if.slave   pix,
    rgb_axis_if.master axis,
    output logic       sof_misalign
);

    pack_state_t state_q, state_d;
    logic [1:0]  res_cnt_q, res_cnt_d;
    logic [23:0] res_dat_q, res_dat_d;
    logic        res_sof_q, res_sof_d;
    logic        mis_d;
    logic        rdy_en_q;

    logic        ld_vld, ld_rdy, ld_user, ld_last;
    logic [31:0] ld_dat;
    logic [3:0]  ld_keep;

    logic        accept;
    logic [1:0]  base_cnt;
    logic [23:0] base_dat;
    logic        base_sof;
    logic [47:0] cat;
    logic [2:0]  n;

    function automatic logic [31:0] pad_word(input logic [31:0] w, input logic [2:0] cnt);
        logic [31:0] r;
        r = w;
        for (int i = 0; i < BYTES_PER_WORD; i++) begin
            if (3'(i) >= cnt) r[i*8 +: 8] = FLUSH_PAD;
        end
        return r;
    endfunction

    assign pix.in_stream_ready = rdy_en_q && (state_q == RUN) && ld_rdy;
    assign accept              = pix.in_valid && pix.in_stream_ready;

    always_comb begin
        state_d   = state_q;
        res_cnt_d = res_cnt_q;
        res_dat_d = res_dat_q;
        res_sof_d = res_sof_q;
        mis_d     = sof_misalign;
        ld_vld    = 1'b0;
        ld_user   = 1'b0;
        ld_last   = 1'b0;
        ld_keep   = 4'hF;

        // An SOF pixel always restarts at lane 0, dropping any leftover bytes.
        if (pix.in_sof) begin
            base_cnt = 2'd0;
            base_dat = 24'd0;
            base_sof = 1'b1;
        end else begin
            base_cnt = res_cnt_q;
            base_dat = res_dat_q;
            base_sof = res_sof_q;
        end
        cat    = {24'd0, base_dat} | ({24'd0, pix.in_r, pix.in_g, pix.in_b} << {base_cnt, 3'b000});
        n      = {1'b0, base_cnt} + 3'(BYTES_PER_PIXEL);
        ld_dat = cat[31:0];

        if (state_q == FLUSH) begin
            ld_dat  = pad_word({8'd0, res_dat_q}, {1'b0, res_cnt_q});
            ld_keep = keep_from_count({1'b0, res_cnt_q});
            ld_last = 1'b1;
            if (ld_rdy) begin
                ld_vld    = 1'b1;
                state_d   = RUN;
                res_cnt_d = 2'd0;
                res_dat_d = 24'd0;
                res_sof_d = 1'b0;
            end
        end else if (accept) begin
            if (pix.in_sof && (res_cnt_q != 2'd0)) mis_d = 1'b1;
            ld_user = base_sof;
            if (pix.in_eol && (n <= 3'(BYTES_PER_WORD))) begin
                ld_vld    = 1'b1;
                ld_dat    = pad_word(cat[31:0], n);
                ld_keep   = keep_from_count(n);
                ld_last   = 1'b1;
                res_cnt_d = 2'd0;
                res_dat_d = 24'd0;
                res_sof_d = 1'b0;
            end else if (n >= 3'(BYTES_PER_WORD)) begin
                ld_vld    = 1'b1;
                res_cnt_d = 2'(n - 3'(BYTES_PER_WORD));
                res_dat_d = {8'd0, cat[47:32]};
                res_sof_d = 1'b0;
                if (pix.in_eol) state_d = FLUSH;
            end else begin
                res_cnt_d = n[1:0];
                res_dat_d = cat[23:0];
                res_sof_d = base_sof;
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q      <= RUN;
            res_cnt_q    <= 2'd0;
            res_dat_q    <= 24'd0;
            res_sof_q    <= 1'b0;
            sof_misalign <= 1'b0;
            rdy_en_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            res_cnt_q    <= res_cnt_d;
            res_dat_q    <= res_dat_d;
            res_sof_q    <= res_sof_d;
            sof_misalign <= mis_d;
            rdy_en_q     <= 1'b1;
        end
    end

    axis_out_reg #(.DATA_W(DATA_W)) u_out_reg (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .ld_vld   (ld_vld),
        .ld_rdy   (ld_rdy),
        .ld_tdata (ld_dat),
        .ld_tkeep (ld_keep),
        .ld_tuser (ld_user),
        .ld_tlast (ld_last),
        .axis     (axis)
    );

endmodule
